// File: rtl/alu_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_arbiter_if
// Purpose  : Bundle of requester handshakes, response return path and the
//            shared ALU input/output bus seen by alu_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_req_arbiter_if #(
  parameter int R = 2,
  parameter int N = 8,
  parameter int M = 4
);
  // requester side
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R-1:0]   req_mode;
  logic [R*M-1:0] req_cmd;
  logic [R*N-1:0] req_opa;
  logic [R*N-1:0] req_opb;
  logic [R-1:0]   req_cin;
  // response side
  logic [R-1:0]   rsp_valid;
  logic [R-1:0]   rsp_ready;
  logic [N+1:0]   rsp_res;
  logic           rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e;
  // shared ALU bus
  logic           alu_ce;
  logic [1:0]     alu_inp_valid;
  logic           alu_mode;
  logic [M-1:0]   alu_cmd;
  logic [N-1:0]   alu_opa, alu_opb;
  logic           alu_cin;
  logic [N+1:0]   alu_res;
  logic           alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;

  // arbiter view
  modport slave (
    input  req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, rsp_ready,
    input  alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
    output req_ready, rsp_valid, rsp_res,
    output rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e,
    output alu_ce, alu_inp_valid, alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin
  );

  // environment view (requesters plus the ALU itself)
  modport master (
    output req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, rsp_ready,
    output alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
    input  req_ready, rsp_valid, rsp_res,
    input  rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e,
    input  alu_ce, alu_inp_valid, alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin
  );
endinterface
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_arbiter
// Purpose  : Round-robin sharing of one ALU among R requesters. Latches the
//            winning operation, issues it for one cycle, waits the
//            command-dependent latency, captures result/flags and returns
//            them over a one-hot response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
  parameter int R         = 2,
  parameter int N         = 8,
  parameter int M         = 4,
  parameter int LAT       = 1,
  parameter int MUL_LAT   = 2,
  parameter int MUL_CMD_A = 9,
  parameter int MUL_CMD_B = 10
) (
  input  wire logic        clk,
  input  wire logic        reset,
  alu_req_arbiter_if.slave bus
);

  localparam int c_GW   = (R > 1) ? $clog2(R) : 1;
  localparam int c_LMAX = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int c_CW   = $clog2(c_LMAX + 1);
  localparam logic [R-1:0] c_ONE = R'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_GW-1:0] r_last_grant;
  logic [c_CW-1:0] r_cnt;
  logic            r_alu_ce;
  logic [1:0]      r_alu_inp_valid;
  logic            r_alu_mode;
  logic [M-1:0]    r_alu_cmd;
  logic [N-1:0]    r_alu_opa, r_alu_opb;
  logic            r_alu_cin;
  logic [R-1:0]    r_rsp_valid;
  logic [N+1:0]    r_rsp_res;
  logic [5:0]      r_rsp_flags;   // {err, oflow, cout, g, l, e}

  logic            w_found;
  logic [c_GW-1:0] w_winner;
  logic            w_sel_mode, w_sel_cin;
  logic [M-1:0]    w_sel_cmd;
  logic [N-1:0]    w_sel_opa, w_sel_opb;
  logic [R-1:0]    w_req_ready;
  logic            w_is_mul;

  // Pick the valid requester closest after last_grant in rotating order
  always_comb begin : p_pick
    int v_dist;
    int v_best;
    v_dist     = 0;
    v_best     = R;
    w_found    = 1'b0;
    w_winner   = '0;
    w_sel_mode = 1'b0;
    w_sel_cin  = 1'b0;
    w_sel_cmd  = '0;
    w_sel_opa  = '0;
    w_sel_opb  = '0;
    for (int i = 0; i < R; i++) begin
      v_dist = (i + 2 * R - int'(r_last_grant) - 1) % R;
      if (bus.req_valid[i] && (v_dist < v_best)) begin
        v_best     = v_dist;
        w_found    = 1'b1;
        w_winner   = c_GW'(i);
        w_sel_mode = bus.req_mode[i];
        w_sel_cin  = bus.req_cin[i];
        w_sel_cmd  = bus.req_cmd[i*M +: M];
        w_sel_opa  = bus.req_opa[i*N +: N];
        w_sel_opb  = bus.req_opb[i*N +: N];
      end
    end
  end

  // Accept pulse to the winner only while idle; forced low during reset
  always_comb begin
    w_req_ready = '0;
    for (int i = 0; i < R; i++) begin
      w_req_ready[i] = (r_state == S_IDLE) && !reset && w_found && (w_winner == c_GW'(i));
    end
  end

  assign w_is_mul = r_alu_mode &&
                    ((r_alu_cmd == M'(MUL_CMD_A)) || (r_alu_cmd == M'(MUL_CMD_B)));

  // Arbitration FSM with registered ALU bus and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_last_grant    <= c_GW'(R - 1);
      r_cnt           <= '0;
      r_alu_ce        <= 1'b0;
      r_alu_inp_valid <= 2'b00;
      r_alu_mode      <= 1'b0;
      r_alu_cmd       <= '0;
      r_alu_opa       <= '0;
      r_alu_opb       <= '0;
      r_alu_cin       <= 1'b0;
      r_rsp_valid     <= '0;
      r_rsp_res       <= '0;
      r_rsp_flags     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last_grant    <= w_winner;
            r_alu_mode      <= w_sel_mode;
            r_alu_cmd       <= w_sel_cmd;
            r_alu_opa       <= w_sel_opa;
            r_alu_opb       <= w_sel_opb;
            r_alu_cin       <= w_sel_cin;
            r_alu_ce        <= 1'b1;
            r_alu_inp_valid <= 2'b11;
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Operand bus keeps its values; only the strobes drop
          r_alu_ce        <= 1'b0;
          r_alu_inp_valid <= 2'b00;
          r_cnt           <= w_is_mul ? c_CW'(MUL_LAT) : c_CW'(LAT);
          r_state         <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt <= c_CW'(1)) begin
            r_rsp_res   <= bus.alu_res;
            r_rsp_flags <= {bus.alu_err, bus.alu_oflow, bus.alu_cout,
                            bus.alu_g, bus.alu_l, bus.alu_e};
            r_rsp_valid <= c_ONE << r_last_grant;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - c_CW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready[r_last_grant]) begin
            r_rsp_valid <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_res       = r_rsp_res;
  assign bus.rsp_err       = r_rsp_flags[5];
  assign bus.rsp_oflow     = r_rsp_flags[4];
  assign bus.rsp_cout      = r_rsp_flags[3];
  assign bus.rsp_g         = r_rsp_flags[2];
  assign bus.rsp_l         = r_rsp_flags[1];
  assign bus.rsp_e         = r_rsp_flags[0];
  assign bus.alu_ce        = r_alu_ce;
  assign bus.alu_inp_valid = r_alu_inp_valid;
  assign bus.alu_mode      = r_alu_mode;
  assign bus.alu_cmd       = r_alu_cmd;
  assign bus.alu_opa       = r_alu_opa;
  assign bus.alu_opb       = r_alu_opb;
  assign bus.alu_cin       = r_alu_cin;

endmodule
`default_nettype wire

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU instance among R requesters; each requester issues a complete operation (mode, cmd, opa, opb, cin) over a valid/ready handshake.
- Round-robin arbitration picks one request at a time, drives the ALU input bus, and waits the command-dependent result latency.
- Captures the ALU flags and result, then returns them to the granted requester over a one-hot response handshake.
- Sits between the ALU and the stimulus/traffic sources, and is the only driver of the ALU input ports.

Parameters:
- R, 2, number of requesters (2..8)
- N, 8, operand width; result width is N+2
- M, 4, command width
- LAT, 1, ALU result latency in cycles after the issue edge for non-multiply commands
- MUL_LAT, 2, ALU result latency for multiply commands
- MUL_CMD_A, 9, first multiply command encoding, valid when mode=1
- MUL_CMD_B, 10, second multiply command encoding, valid when mode=1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  R  per-requester request valid
- req_ready  out  R  one-hot request accept pulse
- req_mode  in  R  per-requester mode
- req_cmd  in  R*M  per-requester command, requester i at bits [i*M +: M]
- req_opa  in  R*N  per-requester operand A
- req_opb  in  R*N  per-requester operand B
- req_cin  in  R  per-requester carry-in
- rsp_valid  out  R  one-hot response valid
- rsp_ready  in  R  per-requester response accept
- rsp_res  out  N+2  captured result
- rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e  out  1 each  captured flags
- alu_ce  out  1  ALU clock enable
- alu_inp_valid  out  2  ALU operand-valid code
- alu_mode  out  1  ALU mode
- alu_cmd  out  M  ALU command
- alu_opa, alu_opb  out  N each  ALU operands
- alu_cin  out  1  ALU carry-in
- alu_res  in  N+2  ALU result
- alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in  1 each  ALU flags

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. On reset: state=IDLE, all outputs 0, last_grant=R-1 so requester 0 wins first. Reset mid-operation discards the operation; no response is produced.
- IDLE: if any req_valid is high, the winner is the first set bit scanning from (last_grant+1) mod R. That cycle, the winner's req_ready=1, the arbiter latches its mode/cmd/opa/opb/cin, sets last_grant=winner, and moves to ISSUE. If no req_valid is high, stay in IDLE.
- req_ready is combinational from req_valid and state, high only in IDLE, at most one bit set.
- Requesters hold req_valid and their fields stable until req_ready. A requester that drops req_valid before being granted is not served.
- ISSUE (exactly 1 cycle): alu_ce=1, alu_inp_valid=2'b11, ALU bus carries the latched fields. Load wait counter with MUL_LAT if mode=1 and cmd is MUL_CMD_A or MUL_CMD_B, else LAT. Go to WAIT.
- All states other than ISSUE: alu_ce=0, alu_inp_valid=2'b00, and alu_mode/cmd/opa/opb/cin hold their last values.
- WAIT: decrement the counter each cycle. On the cycle the counter reaches 1, sample all alu_* outputs into the rsp_* registers and go to RESP. With LAT=1, sampling happens on the first WAIT edge.
- RESP: rsp_valid[last_grant]=1 and rsp_* stay stable until rsp_ready[last_grant]=1. Then clear rsp_valid and go to IDLE. rsp_ready on any other bit is ignored.
- A new request can only be accepted from IDLE, one cycle after the response handshake. Minimum occupancy per operation is lat+3 cycles.
- Invalid commands and ALU errors are passed through unchanged; the arbiter never alters or filters rsp_err.
- Fairness: a continuously asserting requester is served at most once per R grants while others are pending.

Test Plan:
- Reset released, req_valid=2'b01, mode=1, cmd=0, opa=8'h05, opb=8'h03 -> req_ready=01 in the same cycle; one ISSUE cycle with alu_inp_valid=11; rsp_valid=01 with rsp_res=8; rsp_ready=1 returns the FSM to IDLE.
- Both requesters valid continuously for 4 grants -> grant order 0,1,0,1; no back-to-back grants to the same requester.
- mode=1, cmd=MUL_CMD_A -> results sampled MUL_LAT cycles after ISSUE (2), versus LAT (1) for cmd=0; exactly one alu_ce pulse per operation.
- rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_res stable throughout; req_ready stays 0 even while requester 1 is valid.
- reset asserted during WAIT -> all outputs 0 immediately; no rsp_valid after release; requester 0 wins the next arbitration.
- mode=0, cmd=15 (invalid), ALU returns err=1 -> rsp_err=1 forwarded unchanged to the requester.
